// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU-format to int32 converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

  // Operand layout: {sign, exp[EXP_W-1:0], mant[MANT_W-1:0]}, biased exponent.
  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;

  // Result and status geometry.
  localparam int DATA_W = 32;
  localparam int STAT_W = 4;
  // Shift counter covers the largest right shift (E=0 -> 25 positions).
  localparam int CNT_W  = 5;

  // Status bit positions.
  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  // One-hot status masks built from the bit positions.
  localparam logic [STAT_W-1:0] M_EXACT     = STAT_W'(1) << ST_EXACT;
  localparam logic [STAT_W-1:0] M_OVERFLOW  = STAT_W'(1) << ST_OVERFLOW;
  localparam logic [STAT_W-1:0] M_UNDERFLOW = STAT_W'(1) << ST_UNDERFLOW;
  localparam logic [STAT_W-1:0] M_INEXACT   = STAT_W'(1) << ST_INEXACT;

  // Biased exponent at which {1,mant} is already the integer (E = MANT_W).
  localparam logic [EXP_W-1:0] EXP_ALIGN = EXP_W'(BIAS + MANT_W);
  // Smallest biased exponent whose magnitude can no longer fit int32 (E = 31).
  localparam logic [EXP_W-1:0] EXP_OVF   = EXP_W'(BIAS + DATA_W - 1);

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_to_int.sv
// Converts a {sign, exp6, mant25} bias-31 operand to a truncated int32 with status flags.
// Latency: done pulses k+2 edges after the accepting edge, k = |E-25| (2 for zero/underflow/overflow).
// Backpressure: none; start is ignored while busy, a new start is taken in the cycle done pulses.
module fpu_to_int
  import fpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [STAT_W-1:0] status_out
);

  localparam logic [DATA_W-1:0] INT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Sequencer state.
  state_e state_q, state_d;

  // Captured operand; only written on the edge that accepts start.
  logic [DATA_W-1:0] op_q, op_d;

  // Working datapath: sign, shift register, remaining shift count, direction, sticky.
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              left_q, left_d;
  logic              sticky_q, sticky_d;

  // Special-case bypass: mag_q already holds the final result, status is preset.
  logic              spec_q, spec_d;
  logic [STAT_W-1:0] spec_stat_q, spec_stat_d;

  // Registered outputs, held between done pulses.
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STAT_W-1:0] status_q, status_d;

  // Operand field views.
  logic              op_sign;
  logic [EXP_W-1:0]  op_exp;
  logic [MANT_W-1:0] op_mant;

  // Decode helpers for the normal (in-range) case.
  logic              dec_left;
  logic [CNT_W-1:0]  dec_cnt;
  logic [DATA_W-1:0] mag_neg;

  assign op_sign = op_q[DATA_W-1];
  assign op_exp  = op_q[DATA_W-2 -: EXP_W];
  assign op_mant = op_q[MANT_W-1:0];

  // Shift direction and distance so that {1,mant} lands on the integer binary point.
  always_comb begin
    dec_left = (op_exp >= EXP_ALIGN);
    if (dec_left) begin
      dec_cnt = CNT_W'(op_exp - EXP_ALIGN);
    end else begin
      dec_cnt = CNT_W'(EXP_ALIGN - op_exp);
    end
  end

  // Two's-complement of the shifted magnitude for negative operands.
  assign mag_neg = ~mag_q + {{(DATA_W-1){1'b0}}, 1'b1};

  // Next-state and datapath control for one conversion.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    sticky_d    = sticky_q;
    spec_d      = spec_q;
    spec_stat_d = spec_stat_q;
    done_d      = 1'b0;
    data_d      = data_q;
    status_d    = status_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_in;
          state_d = DECODE;
        end
      end

      DECODE: begin
        sign_d      = op_sign;
        sticky_d    = 1'b0;
        left_d      = 1'b0;
        cnt_d       = '0;
        spec_d      = 1'b1;
        spec_stat_d = '0;
        if (op_exp == '0) begin
          // Reserved exponent encodes zero regardless of sign.
          mag_d       = '0;
          spec_stat_d = M_EXACT;
          state_d     = DONE;
        end else if (op_exp < EXP_W'(BIAS)) begin
          // |value| < 1 truncates to zero.
          mag_d       = '0;
          spec_stat_d = M_UNDERFLOW | M_INEXACT;
          state_d     = DONE;
        end else if (op_exp >= EXP_OVF) begin
          // -2^31 exactly is the one representable value at or above 2^31.
          if (op_sign && (op_exp == EXP_OVF) && (op_mant == '0)) begin
            mag_d       = INT_MIN;
            spec_stat_d = M_EXACT;
          end else begin
            mag_d       = op_sign ? INT_MIN : INT_MAX;
            spec_stat_d = M_OVERFLOW;
          end
          state_d = DONE;
        end else begin
          spec_d  = 1'b0;
          mag_d   = {{(DATA_W-MANT_W-1){1'b0}}, 1'b1, op_mant};
          left_d  = dec_left;
          cnt_d   = dec_cnt;
          state_d = (dec_cnt != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[DATA_W-2:0], 1'b0};
        end else begin
          mag_d    = {1'b0, mag_q[DATA_W-1:1]};
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_d = 1'b1;
        if (spec_q) begin
          data_d   = mag_q;
          status_d = spec_stat_q;
        end else begin
          data_d   = sign_q ? mag_neg : mag_q;
          status_d = sticky_q ? M_INEXACT : M_EXACT;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion without a done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      sticky_q    <= 1'b0;
      spec_q      <= 1'b0;
      spec_stat_q <= '0;
      done_q      <= 1'b0;
      data_q      <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sticky_q    <= sticky_d;
      spec_q      <= spec_d;
      spec_stat_q <= spec_stat_d;
      done_q      <= done_d;
      data_q      <= data_d;
      status_q    <= status_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: doc/fpu_to_int.md
FPU_TO_INT -- requirements
Module: fpu_to_int

Interface
REQ-001 SHALL have: clock  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have: start  input  1  conversion request, sampled only in IDLE.
REQ-004 SHALL have: op_in  input  32  operand, FPU format {sign[31], exp[30:25], mant[24:0]}, bias 31.
REQ-005 SHALL have: busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-006 SHALL have: done  output  1  one-cycle pulse, data_out/status_out valid in that cycle.
REQ-007 SHALL have: data_out  output  32  signed two's-complement integer result.
REQ-008 SHALL have: status_out  output  4  [0] EXACT, [1] OVERFLOW, [2] UNDERFLOW, [3] INEXACT.

Function
REQ-009 SHALL convert value (-1)^s * 1.mant * 2^(exp-31) to int32, truncating toward zero.
REQ-010 SHALL use FSM states IDLE, DECODE, SHIFT, DONE; IDLE->DECODE on start, DECODE->SHIFT if k>0 else DONE, SHIFT->DONE when k shifts complete, DONE->IDLE unconditionally.
REQ-011 SHALL in DECODE compute E = exp-31, load 26-bit magnitude {1,mant}, k = |E-25|, direction right if E<25 else left.
REQ-012 SHALL shift magnitude one bit per SHIFT cycle; any 1 shifted out on a right shift SHALL set a sticky bit.
REQ-013 SHALL assert done exactly k+2 rising edges after the edge that sampled start (2 for special cases).
REQ-014 SHALL treat exp=0 as zero: data_out=0, status=EXACT, no SHIFT.
REQ-015 SHALL treat 1<=exp<=30 (E<0) as underflow: data_out=0, status=UNDERFLOW|INEXACT, no SHIFT.
REQ-016 SHALL treat E>=31 as overflow: data_out=0x7FFFFFFF (s=0) or 0x80000000 (s=1), status=OVERFLOW, no SHIFT; exception s=1, exp=62, mant=0 gives 0x80000000 with status EXACT.
REQ-017 SHALL, after shifting, negate the magnitude when s=1 and set INEXACT if sticky else EXACT.
REQ-018 SHALL hold data_out/status_out stable from DONE until the next DONE.
REQ-019 SHALL ignore start while busy; op_in SHALL be captured only on the accepting edge.
REQ-020 SHALL accept a new start in the IDLE cycle immediately following DONE.

Reset
REQ-021 SHALL on reset assert go to IDLE, clear busy, done, data_out, status_out, shift register, counter, sticky.
REQ-022 SHALL abort any conversion in progress on reset, with no done pulse for it.
REQ-023 SHALL ignore start while reset is high.

Structure
REQ-024 SHALL place EXP_W=6, MANT_W=25, BIAS=31, the FSM state enum and status bit index constants in shared package fpu_pkg.
REQ-025 SHALL be a single module; no sub-module warranted, the datapath being one shift register and one counter.

Verification
REQ-026 op_in=0x3E000000 (1.0) -> done at edge 27, data_out=0x00000001, status=4'b0001.
REQ-027 op_in=0x3F000000 (1.5) -> done at edge 27, data_out=0x00000001, status=4'b1000.
REQ-028 op_in=0xC0000000 (-2.0) -> done at edge 26, data_out=0xFFFFFFFE, status=4'b0001.
REQ-029 op_in=0x3C000000 (0.5) -> done at edge 2, data_out=0, status=4'b1100; op_in=0x00000000 -> data_out=0, status=4'b0001.
REQ-030 op_in=0x7C000000 (+2^31) -> data_out=0x7FFFFFFF, status=4'b0010; 0xFC000000 -> 0x80000000, status=4'b0001.
REQ-031 reset pulsed mid-SHIFT of 1.0 -> no done, outputs 0, busy low; start asserted while busy -> ignored, first result unchanged.
